// File: rtl/sr_reg_bank_pkg.sv
// sr_pkg: shared encodings for the sr_reg_bank storage-cell library.
`default_nettype none

package sr_pkg;

  // Global mode encodings, applied to every channel in a given cycle
  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  // Resolution of s=r=1 in SR mode
  localparam int POL_HOLD = 0;
  localparam int POL_SET  = 1;
  localparam int POL_RST  = 2;
  localparam int POL_TOG  = 3;

  localparam int INV_CNT_W = 16;

endpackage : sr_pkg

`default_nettype wire

// File: rtl/sr_reg_bank_cell.sv
// +------------------------------------------------------------------+
// | sr_cell: one storage channel (q plus sticky err) of sr_reg_bank  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module sr_cell
  import sr_pkg::*;
#(
  parameter logic RST_BIT   = 1'b0,
  parameter int   SR_POLICY = POL_HOLD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       s,
  input  logic       r,
  input  logic       err_clr,
  output logic       q,
  output logic       err,
  output logic       err_next,
  output logic       invalid
);

  logic q_next;

  always_comb begin
    q_next  = q;
    invalid = 1'b0;
    if (en) begin
      case (mode)
        MODE_SR: begin
          case ({s, r})
            2'b01:   q_next = 1'b0;
            2'b10:   q_next = 1'b1;
            2'b11: begin
              invalid = 1'b1;
              case (SR_POLICY)
                POL_SET: q_next = 1'b1;
                POL_RST: q_next = 1'b0;
                POL_TOG: q_next = ~q;
                default: q_next = q;
              endcase
            end
            default: q_next = q;
          endcase
        end
        MODE_JK: begin
          case ({s, r})
            2'b01:   q_next = 1'b0;
            2'b10:   q_next = 1'b1;
            2'b11:   q_next = ~q;
            default: q_next = q;
          endcase
        end
        MODE_D:  q_next = s;
        default: q_next = q ^ s;
      endcase
    end
  end

  // A new invalid on the same edge as a clear keeps the flag set
  assign err_next = (err & ~err_clr) | invalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= RST_BIT;
      err <= 1'b0;
    end else begin
      q   <= q_next;
      err <= err_next;
    end
  end

endmodule : sr_cell

`default_nettype wire

// File: rtl/sr_reg_bank.sv
// +------------------------------------------------------------------+
// | sr_reg_bank: WIDTH-channel SR/JK/D/T register bank, sticky errs. |
// | Optional macro SR_INVALID_CNT_EN adds inv_cnt.   Rev 1.0         |
// +------------------------------------------------------------------+
`default_nettype none

module sr_reg_bank
  import sr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RST_VAL   = {WIDTH{1'b0}},
  parameter int               SR_POLICY = POL_HOLD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     s,
  input  logic [WIDTH-1:0]     r,
  input  logic [WIDTH-1:0]     err_clr,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     qn,
  output logic [WIDTH-1:0]     err,
`ifdef SR_INVALID_CNT_EN
  output logic [INV_CNT_W-1:0] inv_cnt,
`endif
  output logic                 any_err
);

  logic [WIDTH-1:0] err_next;
  logic [WIDTH-1:0] invalid;

  if (SR_POLICY < POL_HOLD || SR_POLICY > POL_TOG) begin : g_bad_policy
    $error("sr_reg_bank: SR_POLICY must be 0..3");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell #(
      .RST_BIT   (RST_VAL[i]),
      .SR_POLICY (SR_POLICY)
    ) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .mode     (mode),
      .s        (s[i]),
      .r        (r[i]),
      .err_clr  (err_clr[i]),
      .q        (q[i]),
      .err      (err[i]),
      .err_next (err_next[i]),
      .invalid  (invalid[i])
    );
  end

  assign qn = ~q;

  // Registered from the err next-state so it tracks err on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_err <= 1'b0;
    end else begin
      any_err <= |err_next;
    end
  end

`ifdef SR_INVALID_CNT_EN
  logic any_inv;
  logic clr_all;

  assign any_inv = |invalid;
  assign clr_all = &err_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_cnt <= '0;
    end else if (any_inv) begin
      if (clr_all) begin
        inv_cnt <= INV_CNT_W'(1);
      end else if (inv_cnt != {INV_CNT_W{1'b1}}) begin
        inv_cnt <= inv_cnt + INV_CNT_W'(1);
      end
    end else if (clr_all) begin
      inv_cnt <= '0;
    end
  end
`endif

endmodule : sr_reg_bank

`default_nettype wire
